outport_fifo: RTL and testbench
===============================

# outport_fifo

Buffers words the CPU writes to its output port so that a slow external consumer can drain them with a valid/ready handshake, without stalling the control unit. It sits directly downstream of the datapath's output port. It captures the 32-bit bus value on every output-port write strobe (the `out` instruction's `OUTPORTin` cycle) into a DEPTH-entry circular buffer. It presents the words in order on a first-word-fall-through interface.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, ≥ 2
- WIDTH, 32, data word width

Ports:
- Clock  in  1  rising-edge clock, shared with the datapath
- Reset  in  1  asynchronous, active-high; clears all state
- Clear  in  1  synchronous flush, active-high; same effect as Reset on the next edge
- OUTPORTin  in  1  write strobe from the control unit; one push per cycle it is high
- DBus  in  WIDTH  datapath bus; sampled when OUTPORTin=1
- Out_data  out  WIDTH  oldest buffered word; combinational from storage
- Out_valid  out  1  high when buffer non-empty
- Out_ready  in  1  consumer accepts Out_data this cycle
- Full  out  1  count == DEPTH
- Empty  out  1  count == 0
- Count  out  log2(DEPTH)+1  number of stored words
- Overflow  out  1  sticky; a push was dropped
- Last_word  out  WIDTH  most recently accepted word; debug/display value

## Operation
- Storage is DEPTH×WIDTH registers, with write pointer wr_ptr and read pointer rd_ptr, each log2(DEPTH) bits. Pointers wrap naturally from DEPTH-1 to 0.
- count is an explicit register of width log2(DEPTH)+1. Full and Empty are decoded from count, not from pointer comparison.
- push_req = OUTPORTin. pop = Out_valid & Out_ready.
- push = push_req & (~Full | pop). A write to a full buffer is accepted only if a pop happens in the same cycle.
- On push: mem[wr_ptr] ← DBus, wr_ptr += 1, Last_word ← DBus.
- On pop: rd_ptr += 1.
- count update:
  - +1 on push only
  - −1 on pop only
  - unchanged on both or neither
- Dropped write: push_req & Full & ~pop. The data is discarded, Overflow ← 1, and pointers, count and Last_word are unchanged.
- Overflow stays set until Reset or Clear.
- Out_data = mem[rd_ptr]. Its value is don't-care while Out_valid=0, and the bench must not check it then.
- Out_valid = ~Empty. The consumer may hold Out_ready high permanently.
- Clear has priority over push and pop in the same cycle. wr_ptr, rd_ptr, count, Overflow and Last_word go to 0. Any push or pop in that cycle is ignored. Storage contents are not cleared.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, Overflow=0, Last_word=0. Hence Out_valid=0, Empty=1, Full=0, Count=0. Storage is cleared to 0.
- The block never back-pressures the control unit. Software avoids overflow by polling Count through the input port when required.

## Timing
- Push latency is 1 cycle. A word strobed at edge k drives Out_valid/Out_data from just after edge k, and Count reflects it after edge k.
- Pop takes effect at the edge where Out_valid & Out_ready are both high. The next word, or Out_valid=0, appears after that edge.
- There is no same-cycle bypass. Push while empty with Out_ready=1 yields count 1 after the edge, and the word is popped no earlier than the following edge.
- Full case: push and pop in the same cycle are both performed. Count stays DEPTH, Full stays 1, and no overflow occurs.
- Full deasserts in the cycle after the edge of the first pop from full.
- Reset asserted mid-transfer forces all outputs to their reset values immediately, independent of Clock. Words that were held are lost.
- Clear and Reset act identically on counters and flags. Clear acts only at the clock edge.
- Back-to-back strobes on consecutive cycles are legal, and each one is a separate push.

## Test plan
- After Reset, push 0x11, 0x22, 0x33 on consecutive cycles with Out_ready=0 → Count=3. Then raise Out_ready → Out_data reads 0x11, 0x22, 0x33 on successive cycles, then Out_valid=0, Empty=1.
- Fill with DEPTH=8 pushes 0x0..0x7 → Full=1, Count=8. A 9th push of 0xFF with Out_ready=0 → Overflow=1, Count=8, Last_word=0x7. Draining returns 0x0..0x7 with 0xFF absent.
- While full, push 0xAA with Out_ready=1 in the same cycle → Out_data advances to 0x1, Count=8, Overflow=0. 0xAA emerges last after 0x7.
- Run 20 pushes and 20 pops interleaved with Out_ready toggling every cycle (pointer wrap-around) → output order identical to input order, and Count returns to 0.
- With 3 words held and Overflow=1, assert Clear together with OUTPORTin (data 0x55) → after the edge Count=0, Overflow=0, Last_word=0, Out_valid=0, and 0x55 is not stored.
- Assert Reset asynchronously between edges while Count=5 → Count=0, Empty=1, Out_valid=0 before the next rising edge.

Source files
------------

// File: rtl/outport_fifo.sv
// Output-port FIFO: buffers each word strobed onto the output port and drains
// it first-word-fall-through over a valid/ready handshake. Never stalls the writer.
module outport_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Clear,
    input  logic                     OUTPORTin,
    input  logic [WIDTH-1:0]         DBus,
    output logic [WIDTH-1:0]         Out_data,
    output logic                     Out_valid,
    input  logic                     Out_ready,
    output logic                     Full,
    output logic                     Empty,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Overflow,
    output logic [WIDTH-1:0]         Last_word
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic [WIDTH-1:0] r_last_word;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_full  = (r_count == C_FULL);
    assign w_empty = (r_count == '0);
    assign w_pop   = ~w_empty & Out_ready;
    // A full buffer still accepts a write when a word leaves in the same cycle.
    assign w_push  = OUTPORTin & (~w_full | w_pop);
    assign w_drop  = OUTPORTin & w_full & ~w_pop;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_last_word <= '0;
        end else if (Clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_last_word <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= DBus;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
                r_last_word     <= DBus;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign Out_data  = r_mem[r_rd_ptr];
    assign Out_valid = ~w_empty;
    assign Full      = w_full;
    assign Empty     = w_empty;
    assign Count     = r_count;
    assign Overflow  = r_overflow;
    assign Last_word = r_last_word;

endmodule

// File: tb/tb_outport_fifo.sv
// Bench for outport_fifo: queue scoreboard of accepted words plus a small
// model of count/overflow/last-word, checked around each clock edge.
module tb_outport_fifo;

    localparam int DEPTH = 8;
    localparam int WIDTH = 32;

    logic             Clock = 1'b0;
    logic             Reset = 1'b1;
    logic             Clear = 1'b0;
    logic             OUTPORTin = 1'b0;
    logic [WIDTH-1:0] DBus = '0;
    logic [WIDTH-1:0] Out_data;
    logic             Out_valid;
    logic             Out_ready = 1'b0;
    logic             Full;
    logic             Empty;
    logic [3:0]       Count;
    logic             Overflow;
    logic [WIDTH-1:0] Last_word;

    outport_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .Clock(Clock), .Reset(Reset), .Clear(Clear), .OUTPORTin(OUTPORTin),
        .DBus(DBus), .Out_data(Out_data), .Out_valid(Out_valid),
        .Out_ready(Out_ready), .Full(Full), .Empty(Empty), .Count(Count),
        .Overflow(Overflow), .Last_word(Last_word)
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_bad = 0;

    logic [WIDTH-1:0] q[$];
    logic             m_ovf  = 1'b0;
    logic [WIDTH-1:0] m_last = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(Count), 32'(q.size()));
        chk({tag, ".full"}, 32'(Full), 32'(q.size() == DEPTH));
        chk({tag, ".empty"}, 32'(Empty), 32'(q.size() == 0));
        chk({tag, ".ovf"}, 32'(Overflow), 32'(m_ovf));
        chk({tag, ".last"}, Last_word, m_last);
    endtask

    // One clock cycle: drive inputs on the falling edge, score the handshake
    // just before the rising edge, then update the model for that edge.
    task automatic step(input logic push, input logic [WIDTH-1:0] d,
                        input logic rdy, input logic clr);
        logic             m_valid;
        logic             m_full;
        logic             pop;
        logic [WIDTH-1:0] exp;
        @(negedge Clock);
        OUTPORTin = push;
        DBus      = d;
        Out_ready = rdy;
        Clear     = clr;
        #1;
        m_valid = (q.size() != 0);
        m_full  = (q.size() == DEPTH);
        chk("valid", 32'(Out_valid), 32'(m_valid));
        pop = m_valid && rdy && !clr;
        if (clr) begin
            q.delete();
            m_ovf  = 1'b0;
            m_last = '0;
        end else begin
            if (pop) begin
                exp = q.pop_front();
                chk("data", Out_data, exp);
            end
            if (push) begin
                if (!m_full || pop) begin
                    q.push_back(d);
                    m_last = d;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 3 * DEPTH && q.size() != 0; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
        end
        chk({tag, ".drained"}, 32'(q.size()), 32'd0);
        check_state(tag);
        chk({tag, ".valid_end"}, 32'(Out_valid), 32'd0);
    endtask

    initial begin
        int pushed;
        #1;
        chk("rst_async.count", 32'(Count), 32'd0);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        check_state("reset");
        chk("reset.valid", 32'(Out_valid), 32'd0);

        // in-order delivery with the consumer initially stalled
        step(1'b1, 32'h11, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b0, 1'b0);
        step(1'b1, 32'h33, 1'b0, 1'b0);
        check_state("three");
        drain("three");

        // fill, then drop one write
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        check_state("fill");
        step(1'b1, 32'hFF, 1'b0, 1'b0);
        check_state("drop");
        drain("drop");
        step(1'b0, '0, 1'b0, 1'b1);
        check_state("clr1");

        // simultaneous push and pop while full
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'hAA, 1'b1, 1'b0);
        check_state("fullpp");
        chk("fullpp.head", Out_data, 32'h1);
        drain("fullpp");

        // pointer wrap with ready toggling every cycle
        pushed = 0;
        for (int i = 0; i < 60 && pushed < 20; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                step(1'b1, 32'h100 + 32'(pushed), i[0], 1'b0);
                pushed++;
            end else begin
                step(1'b0, '0, i[0], 1'b0);
            end
        end
        drain("wrap");

        // clear wins over a push, with words held and overflow set
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < DEPTH - 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        check_state("held3");
        step(1'b1, 32'h55, 1'b0, 1'b1);
        check_state("clr2");
        chk("clr2.valid", 32'(Out_valid), 32'd0);
        step(1'b0, '0, 1'b1, 1'b0);
        check_state("clr2.after");

        // asynchronous reset between edges
        for (int i = 0; i < 5; i++) step(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
        check_state("five");
        @(negedge Clock);
        OUTPORTin = 1'b0;
        Out_ready = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        chk("arst.count", 32'(Count), 32'd0);
        chk("arst.empty", 32'(Empty), 32'd1);
        chk("arst.valid", 32'(Out_valid), 32'd0);
        chk("arst.last", Last_word, 32'd0);
        q.delete();
        m_ovf  = 1'b0;
        m_last = '0;
        @(negedge Clock);
        Reset = 1'b0;
        step(1'b0, '0, 1'b1, 1'b0);
        check_state("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
